// File: rtl/mmul_stream_ctrl.sv
// ---------------------------------------------------------------------------
// mmul_stream_ctrl
//
// Byte-stream front/back end for the 3x3 signed 8-bit matmul block.
//   * Deserializes 18 input bytes (A elements 0..8, then B elements 0..8)
//     into the flat 72-bit mat_a / mat_b buses.
//   * Kicks the multiplier with a one-cycle mm_reset pulse, then holds
//     mm_enable until mm_done is sampled high.
//   * Waits SETTLE clocks, captures mm_result, and streams it out as 9 bytes
//     in row-major order. out_last marks element 8.
//
// Element (r,c) of every 72-bit bus sits at bits [(r*3+c)*8 +: 8].
//
// Parameters:
//   SETTLE     clocks spent in SETTLE before mm_result is captured (1..7)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   input byte valid
//   in_ready   controller accepts an input byte (LOAD only)
//   in_data    input byte
//   mat_a      matrix A to the matmul
//   mat_b      matrix B to the matmul
//   mm_reset   one-cycle load/clear pulse to the matmul
//   mm_enable  matmul enable (RUN only)
//   mm_done    matmul done
//   mm_result  matmul product
//   out_valid  output byte valid (SEND only)
//   out_ready  sink accepts the output byte
//   out_data   result element, index 0..8 row-major
//   out_last   high with element 8
//   run_cycles (MMUL_STREAM_PERF_EN only) cycles spent in RUN, saturating
//
// Optional feature macro: MMUL_STREAM_PERF_EN
// ---------------------------------------------------------------------------
module mmul_stream_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [71:0] mat_a,
  output logic [71:0] mat_b,
  output logic        mm_reset,
  output logic        mm_enable,
  input  logic        mm_done,
  input  logic [71:0] mm_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
`ifdef MMUL_STREAM_PERF_EN
  ,
  output logic [7:0]  run_cycles
`endif
);

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_KICK   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  state_t      state, state_next;
  logic [4:0]  byte_idx;     // 0..17 input byte position
  logic [3:0]  elem_idx;     // element slot addressed by byte_idx
  logic [2:0]  settle_cnt;
  logic [3:0]  out_idx;      // 0..8 output element
  logic [71:0] result_buf;
  logic        in_xfer;
  logic        out_xfer;
  logic        settle_done;

  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid && out_ready;
  assign settle_done = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign elem_idx    = (byte_idx < 5'd9) ? byte_idx[3:0] : 4'(byte_idx - 5'd9);

  // -------------------------------------------------------------------------
  // State register and datapath
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LOAD;
      // NOTE: the result buffer is reset along with the control state so
      // out_data reads 0 out of reset rather than stale data.
      mat_a      <= '0;
      mat_b      <= '0;
      byte_idx   <= '0;
      settle_cnt <= '0;
      out_idx    <= '0;
      result_buf <= '0;
    end else begin
      state <= state_next;

      if (in_xfer) begin
        if (byte_idx < 5'd9) mat_a[{elem_idx, 3'b000} +: 8] <= in_data;
        else                 mat_b[{elem_idx, 3'b000} +: 8] <= in_data;
        byte_idx <= (byte_idx == 5'd17) ? 5'd0 : byte_idx + 5'd1;
      end

      if (state == ST_SETTLE) begin
        if (settle_done) begin
          settle_cnt <= '0;
          result_buf <= mm_result;
        end else begin
          settle_cnt <= settle_cnt + 3'd1;
        end
      end

      if (settle_done) begin
        out_idx <= '0;
      end else if (out_xfer) begin
        out_idx <= out_last ? 4'd0 : out_idx + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mm_reset   = 1'b0;
    mm_enable  = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;

    unique case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_xfer && byte_idx == 5'd17) state_next = ST_KICK;
      end
      ST_KICK: begin
        mm_reset   = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        mm_enable = 1'b1;
        if (mm_done) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) state_next = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = result_buf[{out_idx, 3'b000} +: 8];
        out_last  = (out_idx == 4'd8);
        if (out_ready && out_idx == 4'd8) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

`ifdef MMUL_STREAM_PERF_EN
  // Cycles spent in RUN for the most recent operation; includes the cycle
  // in which mm_done is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles <= '0;
    end else if (state == ST_KICK) begin
      run_cycles <= '0;
    end else if (state == ST_RUN && run_cycles != 8'hFF) begin
      run_cycles <= run_cycles + 8'd1;
    end
  end
`endif

endmodule

// File: doc/mmul_stream_ctrl.md
Name: mmul_stream_ctrl

Overview:
Byte-stream front/back end for the 3x3 signed 8-bit matmul block.
- Deserializes 18 input bytes into flat 72-bit mat_a/mat_b buses.
- Kicks the multiplier with a reset pulse followed by an enable phase, then waits for done.
- Captures the 72-bit result and serializes it back out as 9 bytes.
- Sits between a host byte interface (valid/ready) and one matmul instance.

Parameters:
SETTLE, 1, clocks waited in SETTLE after mm_done is sampled high before mm_result is captured (range 1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input byte valid
in_ready  output  1  controller accepts input byte
in_data  input  8  input byte: A elements 0..8, then B elements 0..8
mat_a  output  72  to matmul; element (r,c) at bits [(r*3+c)*8 +: 8]
mat_b  output  72  to matmul; same packing
mm_reset  output  1  one-cycle load/clear pulse to matmul reset
mm_enable  output  1  matmul enable
mm_done  input  1  matmul done
mm_result  input  72  matmul product, same packing
out_valid  output  1  output byte valid
out_ready  input  1  sink accepts output byte
out_data  output  8  result element, index 0..8 row-major
out_last  output  1  high with element 8

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=LOAD; in_ready=1.
  - out_valid=0, out_last=0, out_data=0.
  - mm_reset=0, mm_enable=0.
  - mat_a=0, mat_b=0; byte index=0; settle counter=0; captured result=0.
- A byte transfers on a clock when in_valid&&in_ready; an output byte transfers when out_valid&&out_ready.
- LOAD:
  - in_ready=1.
  - Byte k (0..17) writes mat_a element k (k<9) or mat_b element k-9.
  - No transfer means no change.
  - On transfer of byte 17 -> KICK.
- KICK (1 cycle):
  - mm_reset=1, in_ready=0.
  - mat_a/mat_b are stable from this cycle until the next LOAD transfer.
  - -> RUN.
- RUN:
  - mm_enable=1.
  - mm_done sampled high -> SETTLE, with mm_enable low from the next cycle.
  - No timeout.
- SETTLE:
  - Count SETTLE cycles.
  - On the final count, register mm_result into the output buffer -> SEND, element index 0.
- SEND:
  - out_valid=1; out_data=buffer element idx; out_last=(idx==8).
  - out_data holds stable while out_ready=0.
  - Transfer advances idx.
  - Transfer with out_last -> LOAD: out_valid=0, in_ready=1 in the next cycle.
- Data is passed through unchanged; no arithmetic on elements. Result bytes are the two's-complement low 8 bits produced by the multiplier.
- in_ready is 0 in KICK/RUN/SETTLE/SEND; input bytes presented then are not consumed.
- mm_done asserted outside RUN is ignored.
- Back-to-back: a new LOAD may begin the cycle after the last output transfer.

Optional Feature:
MMUL_STREAM_PERF_EN
- Defined:
  - Adds output port run_cycles[7:0].
  - Counter clears on KICK and increments each cycle in RUN, saturating at 255.
  - Value holds after RUN until the next KICK; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- A=identity (bytes 01,00,00,00,01,00,00,00,01), B=01..09 -> out 01,02,...,09; out_last only on 09; mm_reset exactly one cycle.
- A all 02, B all 03 -> nine bytes 0x12.
- A all 0x64, B all 0x64 -> nine bytes 0x30 (each product truncated to 0x10, then summed with 8-bit wrap).
- A[0][0]=0xFF, other A elements 0, B all 05 -> element 0..2 = 0xFB, rest 0x00; hold out_ready=0 for 5 cycles mid-stream -> out_data/out_valid stable, no byte lost or duplicated.
- Reset asserted after 7 input bytes, then a full new 18-byte load -> result reflects the new matrices only; mat_a/mat_b read 0 in the cycle after reset.
- With MMUL_STREAM_PERF_EN, identity x identity -> run_cycles=28 against the team matmul (27 compute cycles + 1 done-sample cycle); without it, the bench compiles without the port.
